activation_result_writer: RTL and testbench
===========================================

# activation_result_writer

Consumes the row stream leaving the activation stage and writes it into the result BRAM port. It accepts one `DESIGN_SIZE`-lane row per cycle while `in_data_available` is high. For each row it generates a strided BRAM address, a per-lane write-enable and a registered write word. When a full tile of `DESIGN_SIZE` rows has been written, it reports completion to the top-level control FSM.

## Interface
Parameters:
- DESIGN_SIZE, `DESIGN_SIZE`, lanes per row and rows per tile
- DWIDTH, `DWIDTH`, bits per lane
- AWIDTH, `AWIDTH`, BRAM address width
- MASK_WIDTH, `MASK_WIDTH`, per-lane write-enable width (= DESIGN_SIZE)

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable_writer  in  1  level; low forces IDLE and clears all state
- base_address  in  AWIDTH  address of row 0; sampled on IDLE→WRITE
- address_stride  in  AWIDTH  address increment per row; sampled on IDLE→WRITE
- validity_mask  in  MASK_WIDTH  lane i writable when bit i = 1
- in_data_available  in  1  a valid row is present on inp_data this cycle
- inp_data  in  DESIGN_SIZE*DWIDTH  activation output row, lane i at [i*DWIDTH +: DWIDTH]
- bram_addr  out  AWIDTH  write address
- bram_wdata  out  DESIGN_SIZE*DWIDTH  write data
- bram_we  out  MASK_WIDTH  per-lane write strobe
- done_write  out  1  tile fully written; held until enable_writer is low
- overflow  out  1  sticky; a row arrived after the tile completed

## Operation
- Reset values: bram_addr=0, bram_wdata=0, bram_we=0, done_write=0, overflow=0. Internally: FSM=IDLE, row_count=0.
- FSM states: IDLE, WRITE, DONE.
- IDLE → WRITE: when enable_writer=1. On this transition, latch base_address and address_stride, and set next_addr=base_address.
- WRITE:
  - On each cycle with in_data_available=1, issue one write: bram_addr=next_addr, bram_wdata=inp_data, bram_we=validity_mask.
  - Then next_addr += stride and row_count += 1.
  - Cycles with in_data_available=0 are bubbles: bram_we=0, counters hold, no timeout.
- WRITE → DONE: when the row issued is row DESIGN_SIZE-1.
- DONE:
  - done_write=1, bram_we=0.
  - Any in_data_available=1 sets overflow; the row is dropped.
- Any state → IDLE: when enable_writer=0 (the next edge clears state as reset does). The same applies to reset=1 mid-tile; a partially written tile is abandoned with no further strobes.
- Address arithmetic is unsigned modulo 2^AWIDTH. Wrap past the top of the address space is silent and is not an error.
- Lanes with a validity_mask bit of 0 still carry inp_data on bram_wdata; only their strobe is suppressed.
- validity_mask is sampled per row, together with inp_data.

## Timing
- Without ACT_WRITER_PIPE_EN:
  - A row accepted at edge N appears on bram_* after edge N (1-cycle latency).
  - done_write rises in the same cycle bram_we is presented for the last row.
- Back-to-back rows produce back-to-back writes; throughput is 1 row/cycle.
- enable_writer rising at edge N: the first row can be accepted at edge N+1. in_data_available during the IDLE cycle is ignored.
- If reset and enable_writer are both asserted, reset wins.

## Configuration
- ACT_WRITER_PIPE_EN defined:
  - Adds a second output register stage on bram_addr, bram_wdata and bram_we, for BRAM placement timing.
  - Latency becomes 2 cycles.
  - done_write is delayed equally, so it still coincides with the last strobe.
  - enable_writer=0 or reset also flushes the pipe stage.
- Not defined: 1-cycle latency as described above.

## Test plan
- Contiguous tile: DESIGN_SIZE=4, DWIDTH=8, base=0x010, stride=1, mask=4'hF; rows 0x04030201..0x10 0F0E0D arrive back-to-back.
  - Required: writes at 0x010..0x013 with matching data and we=4'hF.
  - done_write=1 with the 4th strobe, then bram_we=0.
- Bubbles and stride: base=0x100, stride=4; in_data_available pattern 1,0,0,1,1,0,1.
  - Required: exactly 4 writes at 0x100, 0x104, 0x108, 0x10C.
  - No strobe in bubble cycles.
- Mask: mask=4'b0101 on all rows.
  - Required: bram_we=4'b0101 on every write; data still present on all lanes.
- Wrap and overflow: AWIDTH=10, base=0x3FE, stride=1, then 5 rows.
  - Required: addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - 5th row dropped, overflow=1 and held until enable_writer=0.
- Abort: reset=1 after 2 rows, then re-enable with base=0x020.
  - Required: all outputs 0 one cycle after reset.
  - New tile starts at 0x020 with row_count=0 and no stale done_write.
- With ACT_WRITER_PIPE_EN: repeat the contiguous-tile test.
  - Required: each strobe is one cycle later than without the macro; addresses and data identical; done_write aligned with the last strobe.

Source files
------------

// File: rtl/activation_result_writer.sv
// Writes activation-stage rows into the result BRAM at strided addresses and flags tile completion.
// Optional ACT_WRITER_PIPE_EN adds a second output register stage (2-cycle latency).
module activation_result_writer #(
   parameter int DESIGN_SIZE = 4,
   parameter int DWIDTH      = 8,
   parameter int AWIDTH      = 10,
   parameter int MASK_WIDTH  = DESIGN_SIZE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable_writer,
   input  logic [AWIDTH-1:0]             base_address,
   input  logic [AWIDTH-1:0]             address_stride,
   input  logic [MASK_WIDTH-1:0]         validity_mask,
   input  logic                          in_data_available,
   input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
   output logic [AWIDTH-1:0]             bram_addr,
   output logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata,
   output logic [MASK_WIDTH-1:0]         bram_we,
   output logic                          done_write,
   output logic                          overflow
);

   // state   | meaning
   // S_IDLE  | waiting for enable_writer; base/stride latched on exit
   // S_WRITE | issuing one write per valid row
   // S_DONE  | tile complete; further rows dropped and flagged
   localparam int CW = $clog2(DESIGN_SIZE + 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

   state_t                        state, state_nxt;
   logic [AWIDTH-1:0]             next_addr;
   logic [AWIDTH-1:0]             stride;
   logic [CW-1:0]                 row_count;
   logic                          clear;
   logic                          issue;
   logic                          last_row;
   logic                          tile_done;
   logic [AWIDTH-1:0]             addr_s1;
   logic [DESIGN_SIZE*DWIDTH-1:0] data_s1;
   logic [MASK_WIDTH-1:0]         we_s1;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable_writer) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_WRITE;
            S_WRITE: if (last_row) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      clear     = reset || !enable_writer;
      issue     = (state == S_WRITE) && in_data_available;
      last_row  = issue && (row_count == CW'(DESIGN_SIZE - 1));
      tile_done = (state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         next_addr <= '0;
         stride    <= '0;
         row_count <= '0;
         addr_s1   <= '0;
         data_s1   <= '0;
         we_s1     <= '0;
         overflow  <= 1'b0;
      end else begin
         if (state == S_IDLE) begin
            next_addr <= base_address;
            stride    <= address_stride;
            row_count <= '0;
         end
         if (issue) begin
            addr_s1   <= next_addr;
            data_s1   <= inp_data;
            next_addr <= next_addr + stride;
            row_count <= row_count + CW'(1);
         end
         we_s1 <= issue ? validity_mask : '0;
         if (tile_done && in_data_available) overflow <= 1'b1;
      end
   end

`ifdef ACT_WRITER_PIPE_EN
   // Second stage for BRAM placement; done is delayed alongside so it stays on the last strobe.
   always_ff @(posedge clk) begin
      if (clear) begin
         bram_addr  <= '0;
         bram_wdata <= '0;
         bram_we    <= '0;
         done_write <= 1'b0;
      end else begin
         bram_addr  <= addr_s1;
         bram_wdata <= data_s1;
         bram_we    <= we_s1;
         done_write <= tile_done;
      end
   end
`else
   always_comb begin
      bram_addr  = addr_s1;
      bram_wdata = data_s1;
      bram_we    = we_s1;
      done_write = tile_done;
   end
`endif

endmodule

// File: tb/tb_activation_result_writer.sv
// Randomized and directed bench for activation_result_writer against a tile-level reference model.
module tb_activation_result_writer;
   localparam int DS = 4;
   localparam int DW = 8;
   localparam int AW = 10;
`ifdef ACT_WRITER_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk;
   logic            reset;
   logic            enable_writer;
   logic [AW-1:0]   base_address;
   logic [AW-1:0]   address_stride;
   logic [DS-1:0]   validity_mask;
   logic            in_data_available;
   logic [DS*DW-1:0] inp_data;
   logic [AW-1:0]   bram_addr;
   logic [DS*DW-1:0] bram_wdata;
   logic [DS-1:0]   bram_we;
   logic            done_write;
   logic            overflow;

   activation_result_writer #(.DESIGN_SIZE(DS), .DWIDTH(DW), .AWIDTH(AW), .MASK_WIDTH(DS)) dut (
      .clk(clk), .reset(reset), .enable_writer(enable_writer),
      .base_address(base_address), .address_stride(address_stride),
      .validity_mask(validity_mask), .in_data_available(in_data_available),
      .inp_data(inp_data), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
      .bram_we(bram_we), .done_write(done_write), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Tile-level model: a tile is "active" once enable has been seen; row k goes to base + k*stride.
   bit               m_active;
   int               m_rows;
   bit               m_ovf;
   logic [AW-1:0]    m_base, m_stride;
   logic [AW-1:0]    s1_addr, p2_addr, e_addr;
   logic [DS*DW-1:0] s1_data, p2_data, e_data;
   logic [DS-1:0]    s1_we, p2_we, e_we;
   bit               s1_clr, p2_clr, p2_done, e_clr, e_done;

   logic [AW-1:0]    log_addr[$];
   logic [DS*DW-1:0] log_data[$];
   logic [DS-1:0]    log_we[$];
   bit               log_done[$];
   int               log_cyc[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   task automatic model_edge();
      bit clr;
      bit done_old;
      logic [31:0] prod;
      clr      = reset || !enable_writer;
      done_old = m_active && (m_rows == DS);
      if (clr) begin
         p2_we = '0; p2_addr = '0; p2_data = '0; p2_done = 1'b0; p2_clr = 1'b1;
      end else begin
         p2_we = s1_we; p2_addr = s1_addr; p2_data = s1_data; p2_done = done_old; p2_clr = 1'b0;
      end
      if (clr) begin
         m_active = 0; m_rows = 0; m_ovf = 0;
         s1_we = '0; s1_addr = '0; s1_data = '0; s1_clr = 1'b1;
      end else begin
         s1_clr = 1'b0;
         s1_we  = '0;
         if (!m_active) begin
            m_active = 1; m_rows = 0; m_base = base_address; m_stride = address_stride;
         end else if (in_data_available) begin
            if (m_rows < DS) begin
               prod    = 32'(m_base) + 32'(m_rows) * 32'(m_stride);
               s1_addr = prod[AW-1:0];
               s1_data = inp_data;
               s1_we   = validity_mask;
               m_rows++;
            end else begin
               m_ovf = 1;
            end
         end
      end
      if (LAT == 1) begin
         e_we = s1_we; e_addr = s1_addr; e_data = s1_data; e_clr = s1_clr;
         e_done = m_active && (m_rows == DS);
      end else begin
         e_we = p2_we; e_addr = p2_addr; e_data = p2_data; e_clr = p2_clr; e_done = p2_done;
      end
   endtask

   task automatic compare();
      check("bram_we", 64'(bram_we), 64'(e_we));
      check("done_write", 64'(done_write), 64'(e_done));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (e_we != '0 || e_clr) begin
         check("bram_addr", 64'(bram_addr), 64'(e_addr));
         check("bram_wdata", 64'(bram_wdata), 64'(e_data));
      end
      if (bram_we != '0) begin
         log_addr.push_back(bram_addr);
         log_data.push_back(bram_wdata);
         log_we.push_back(bram_we);
         log_done.push_back(done_write);
         log_cyc.push_back(cyc);
      end
   endtask

   task automatic step(input logic r, input logic en, input logic ida,
                       input logic [DS-1:0] msk, input logic [DS*DW-1:0] dat);
      reset = r; enable_writer = en; in_data_available = ida;
      validity_mask = msk; inp_data = dat;
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic clear_log();
      log_addr.delete(); log_data.delete(); log_we.delete(); log_done.delete(); log_cyc.delete();
   endtask

   logic [DS*DW-1:0] rows_c[4];
   int               pat[7];
   int               first_acc;

   initial begin
      m_active = 0; m_rows = 0; m_ovf = 0;
      s1_we = '0; s1_addr = '0; s1_data = '0; s1_clr = 0;
      p2_we = '0; p2_addr = '0; p2_data = '0; p2_done = 0; p2_clr = 0;
      base_address = '0; address_stride = '0;
      rows_c[0] = 32'h04030201; rows_c[1] = 32'h08070605;
      rows_c[2] = 32'h0C0B0A09; rows_c[3] = 32'h100F0E0D;

      // reset state
      step(1, 0, 0, '0, '0);
      step(1, 1, 1, 4'hF, 32'hFFFF_FFFF);
      check("reset_addr", 64'(bram_addr), 64'h0);
      check("reset_wdata", 64'(bram_wdata), 64'h0);
      check("reset_we", 64'(bram_we), 64'h0);
      check("reset_done", 64'(done_write), 64'h0);
      check("reset_ovf", 64'(overflow), 64'h0);
      step(0, 0, 0, '0, '0);

      // contiguous tile
      base_address = 10'h010; address_stride = 10'd1;
      clear_log();
      step(0, 1, 1, 4'hF, 32'hDEADBEEF);
      first_acc = cyc + 1;
      for (int i = 0; i < 4; i++) step(0, 1, 1, 4'hF, rows_c[i]);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 4'hF, '0);
      check("t1_nwrites", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("t1_addr", 64'(log_addr[i]), 64'(10'h010 + i));
            check("t1_data", 64'(log_data[i]), 64'(rows_c[i]));
            check("t1_we", 64'(log_we[i]), 64'hF);
            check("t1_done_on_strobe", 64'(log_done[i]), 64'(i == 3));
         end
         check("t1_latency", 64'(log_cyc[0] - first_acc), 64'(LAT - 1));
      end
      check("t1_done_held", 64'(done_write), 64'h1);
      check("t1_ovf", 64'(overflow), 64'h0);
      step(0, 0, 0, '0, '0);
      check("t1_done_cleared", 64'(done_write), 64'h0);

      // bubbles and stride
      base_address = 10'h100; address_stride = 10'd4;
      pat = '{1, 0, 0, 1, 1, 0, 1};
      clear_log();
      step(0, 1, 0, 4'hF, '0);
      for (int i = 0; i < 7; i++) step(0, 1, pat[i][0], 4'hF, $urandom());
      for (int i = 0; i < 2; i++) step(0, 1, 0, 4'hF, '0);
      check("t2_nwrites", 64'(log_addr.size()), 64'd4);
      for (int i = 0; i < log_addr.size() && i < 4; i++)
         check("t2_addr", 64'(log_addr[i]), 64'(10'h100 + 4 * i));
      step(0, 0, 0, '0, '0);

      // mask
      base_address = 10'h040; address_stride = 10'd2;
      clear_log();
      step(0, 1, 0, 4'b0101, '0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 4'b0101, 32'hA5A5_0000 | 32'(i));
      for (int i = 0; i < 2; i++) step(0, 1, 0, 4'b0101, '0);
      check("t3_nwrites", 64'(log_addr.size()), 64'd4);
      for (int i = 0; i < log_addr.size() && i < 4; i++) begin
         check("t3_we", 64'(log_we[i]), 64'b0101);
         check("t3_data", 64'(log_data[i]), 64'(32'hA5A5_0000 | 32'(i)));
      end
      step(0, 0, 0, '0, '0);

      // wrap and overflow
      base_address = 10'h3FE; address_stride = 10'd1;
      clear_log();
      step(0, 1, 0, 4'hF, '0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 4'hF, $urandom());
      for (int i = 0; i < 3; i++) step(0, 1, 0, 4'hF, '0);
      check("t4_nwrites", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) begin
         check("t4_addr0", 64'(log_addr[0]), 64'h3FE);
         check("t4_addr1", 64'(log_addr[1]), 64'h3FF);
         check("t4_addr2", 64'(log_addr[2]), 64'h000);
         check("t4_addr3", 64'(log_addr[3]), 64'h001);
      end
      check("t4_ovf_held", 64'(overflow), 64'h1);
      step(0, 0, 0, '0, '0);
      check("t4_ovf_cleared", 64'(overflow), 64'h0);

      // abort mid-tile, then restart
      base_address = 10'h200; address_stride = 10'd1;
      step(0, 1, 0, 4'hF, '0);
      step(0, 1, 1, 4'hF, 32'h1111_1111);
      step(0, 1, 1, 4'hF, 32'h2222_2222);
      step(1, 1, 1, 4'hF, 32'h3333_3333);
      check("t5_addr", 64'(bram_addr), 64'h0);
      check("t5_wdata", 64'(bram_wdata), 64'h0);
      check("t5_we", 64'(bram_we), 64'h0);
      check("t5_done", 64'(done_write), 64'h0);
      base_address = 10'h020;
      clear_log();
      step(0, 1, 1, 4'hF, 32'h4444_4444);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 4'hF, 32'h5000_0000 + 32'(i));
      for (int i = 0; i < 2; i++) step(0, 1, 0, 4'hF, '0);
      check("t5_nwrites", 64'(log_addr.size()), 64'd4);
      if (log_addr.size() == 4) begin
         check("t5_first_addr", 64'(log_addr[0]), 64'h020);
         check("t5_no_stale_done", 64'(log_done[2]), 64'h0);
      end
      step(0, 0, 0, '0, '0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            base_address   = AW'($urandom());
            address_stride = AW'($urandom());
         end
         step(($urandom_range(0, 60) == 0), ($urandom_range(0, 25) != 0),
              $urandom_range(0, 1), DS'($urandom()), $urandom());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
